// File: rtl/spi_master_tx.sv
// SPI master for the calculator link: shifts out {operacion, num2, num1} MSB first,
// captures the slave's MISO echo and reports whether it matches the sent frame.
module spi_master_tx #(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] num1,
  input  logic [3:0] num2,
  input  logic [1:0] operacion,
  input  logic       MISO,
  output logic       sclk,
  output logic       SS,
  output logic       MOSI,
  output logic       busy,
  output logic       done,
  output logic [9:0] rx_data,
  output logic       echo_ok,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LEAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] TRAIL = 2'd3;

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF_PERIOD - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    tx;
  logic [9:0]    tx_sr;
  logic [9:0]    rx_sr;

  assign fsm_state = state;

  // Handshake: start is only looked at in IDLE; busy covers LEAD..TRAIL and
  // done pulses for exactly one cycle as the FSM re-enters IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      tx      <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sclk    <= 1'b0;
      SS      <= 1'b0;
      MOSI    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      echo_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx      <= {operacion, num2, num1};
            tx_sr   <= {operacion, num2, num1};
            MOSI    <= operacion[1];
            SS      <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            rx_sr   <= '0;
            state   <= LEAD;
          end
        end
        LEAD: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            sclk    <= 1'b1;
            rx_sr   <= {rx_sr[8:0], MISO};
            bit_cnt <= bit_cnt + 4'd1;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (!sclk) begin
              sclk    <= 1'b1;
              rx_sr   <= {rx_sr[8:0], MISO};
              bit_cnt <= bit_cnt + 4'd1;
            end else begin
              // MOSI only moves on falling edges so it is stable around each rise.
              sclk <= 1'b0;
              if (bit_cnt == 4'd10) begin
                MOSI  <= 1'b0;
                state <= TRAIL;
              end else begin
                MOSI  <= tx_sr[8];
                tx_sr <= {tx_sr[8:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            SS      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            rx_data <= rx_sr;
            echo_ok <= (rx_sr == tx);
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: directed frames, a slave shift model on MISO/MOSI and a
// scoreboard that checks every done pulse against queued expectations.
module tb_spi_master_tx;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num1 = '0, num2 = '0;
  logic [1:0] operacion = '0;
  logic       MISO;
  logic       sclk, SS, MOSI, busy, done, echo_ok;
  logic [9:0] rx_data;
  logic [1:0] fsm_state;

  logic       start_b = 1'b0;
  logic [3:0] num1_b = '0, num2_b = '0;
  logic [1:0] op_b = '0;
  logic       miso_b;
  logic       sclk_b, ss_b, mosi_b, busy_b, done_b, ok_b;
  logic [9:0] rx_b;
  logic [1:0] state_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;
  int slave_cnt = 0;
  logic [9:0] slave_sr = '0;
  logic [20:0] exp_q[$];
  int exp_cyc_q[$];
  logic [20:0] mon_e;
  int mon_c;

  spi_master_tx #(.HALF_PERIOD(HALF)) dut (
    .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2),
    .operacion(operacion), .MISO(MISO), .sclk(sclk), .SS(SS), .MOSI(MOSI),
    .busy(busy), .done(done), .rx_data(rx_data), .echo_ok(echo_ok),
    .fsm_state(fsm_state)
  );

  spi_master_tx #(.HALF_PERIOD(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .num1(num1_b), .num2(num2_b),
    .operacion(op_b), .MISO(miso_b), .sclk(sclk_b), .SS(ss_b), .MOSI(mosi_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .echo_ok(ok_b),
    .fsm_state(state_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model: mode 0 loopback, 1 slave in reset, 2 loopback with bit 5 inverted
  assign MISO = (mode == 1) ? 1'b1 : ((MOSI & SS) ^ ((mode == 2) && (slave_cnt == 4)));
  assign miso_b = mosi_b & ss_b;
  always @(posedge SS) slave_cnt = 0;
  always @(posedge sclk) begin
    slave_sr = {slave_sr[8:0], MOSI};
    slave_cnt = slave_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input bit sync, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op);
    logic [9:0] tx, rx;
    if (sync) @(negedge clk);
    tx = {op, b, a};
    rx = (mode == 1) ? 10'h3FF : (mode == 2) ? (tx ^ 10'h020) : tx;
    num1 = a; num2 = b; operacion = op; start = 1'b1;
    exp_q.push_back({tx, rx, rx == tx});
    exp_cyc_q.push_back(cyc + 1 + 21 * HALF);
    @(negedge clk);
    start = 1'b0;
    check("cycle1_ss", SS, 1);
    check("cycle1_busy", busy, 1);
    check("cycle1_mosi", MOSI, tx[9]);
    num1 = 4'($urandom_range(0, 15));
    num2 = 4'($urandom_range(0, 15));
    operacion = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", seen, 1);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("done_cycle", cyc, mon_c);
        check("rx_data", {22'd0, rx_data}, {22'd0, mon_e[10:1]});
        check("echo_ok", echo_ok, mon_e[0]);
        check("slave_sr", {22'd0, slave_sr}, {22'd0, mon_e[20:11]});
        check("ss_low_at_done", SS, 0);
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  initial begin
    #1;
    check("rst_outs", {sclk, SS, MOSI, busy, done, echo_ok}, 0);
    check("rst_rx", rx_data, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // basic loopback frame 10'h23A
    send(1, 4'hA, 4'h3, 2'b10);
    wait_done();

    // slave held in reset
    mode = 1;
    send(1, 4'h0, 4'h0, 2'b00);
    wait_done();
    send(1, 4'hF, 4'hF, 2'b11);
    wait_done();

    // start while busy is ignored; start coincident with done is accepted
    mode = 0;
    send(1, 4'hC, 4'h5, 2'b01);
    repeat (39) @(negedge clk);
    num1 = 4'h3; num2 = 4'h3; operacion = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_ignore", busy, 1);
    wait_done();
    send(0, 4'h7, 4'h9, 2'b10);
    wait_done();

    // reset mid-frame
    send(1, 4'h1, 4'hE, 2'b01);
    repeat (29) @(negedge clk);
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    check("abort_outs", {sclk, SS, MOSI, busy, done, echo_ok}, 0);
    check("abort_rx", rx_data, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    rst = 1'b1;
    send(1, 4'h6, 4'h4, 2'b11);
    wait_done();

    // corrupted echo on bit 5
    mode = 2;
    send(1, 4'h5, 4'h5, 2'b01);
    wait_done();
    mode = 0;

    // minimum divider on the second instance
    @(negedge clk);
    num1_b = 4'h5; num2_b = 4'h5; op_b = 2'b01; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("h1_ss", ss_b, 1);
    for (int n = 1; n <= 21; n++) begin
      check("h1_sclk", sclk_b, (n >= 2 && n <= 20 && (n % 2) == 0) ? 1 : 0);
      @(negedge clk);
    end
    check("h1_done", done_b, 1);
    check("h1_rx", rx_b, 10'h155);
    check("h1_echo_ok", ok_b, 1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
